ro_race_counter: RTL and testbench

- Multi-channel, parametrised successor to the single post-mux counter: NUM_CH channels each count pulses on synchronised ring-oscillator enable lines.
- The block runs one measurement per start request, then reports a winner index, tie flag and all channel counts for PUF response-bit generation.
- Two modes: race (first channel to GOAL wins) and window (fixed clk-cycle window, highest count wins).
- Sits after the RO select muxes and before the response comparator and shift logic.

---
 rtl/ro_race_counter_if.sv | 28 ++
 rtl/ro_race_counter.sv | 141 ++++++++++++++
 tb/tb_ro_race_counter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ro_race_counter_if.sv
// Handshake and result bundle between a measurement controller and ro_race_counter.
// The controller side uses the master modport; the counter block uses slave.
interface ro_race_counter_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 22,
    parameter int WIN_W  = 1
);
    logic                      start;
    logic                      mode;
    logic                      abort;
    logic [NUM_CH-1:0]         count_en;
    logic                      busy;
    logic                      done;
    logic                      timeout;
    logic                      tie;
    logic [WIN_W-1:0]          winner;
    logic [NUM_CH*CNT_W-1:0]   counts;

    modport master (
        output start, mode, abort, count_en,
        input  busy, done, timeout, tie, winner, counts
    );

    modport slave (
        input  start, mode, abort, count_en,
        output busy, done, timeout, tie, winner, counts
    );
endinterface

// File: rtl/ro_race_counter.sv
// Multi-channel ring-oscillator pulse counter for PUF response generation.
// One measurement per start: race to GOAL or fixed window, then report winner/tie/counts.
module ro_race_counter #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 22,
    parameter int GOAL       = 2**21,
    parameter int WINDOW     = 4096,
    parameter int MAX_CYCLES = 2**22,
    parameter int WIN_W      = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH)
) (
    input  logic               clk,
    input  logic               reset,
    ro_race_counter_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CYC_TOP = (MAX_CYCLES > WINDOW) ? MAX_CYCLES : WINDOW;
    localparam int CYC_W   = $clog2(CYC_TOP + 1);

    localparam logic [CNT_W-1:0] SAT    = '1;
    localparam logic [CNT_W-1:0] GOAL_V = CNT_W'(GOAL);

    logic [1:0]        state;
    logic              mode_r;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [CNT_W-1:0]  nxt [NUM_CH];
    logic [CYC_W-1:0]  cyc;
    logic [CYC_W-1:0]  cyc_nxt;
    logic [NUM_CH-1:0] hit;
    logic              finish;
    logic              found;
    logic [CNT_W-1:0]  best;
    logic [WIN_W-1:0]  win_c;
    logic              tie_c;
    logic              to_c;
    logic [WIN_W-1:0]  winner_r;
    logic              tie_r;
    logic              timeout_r;

    // Next counter values saturate; the finish decision and results are judged on them
    // so that the edge entering DONE already includes its own count_en sample.
    always_comb begin
        finish  = 1'b0;
        found   = 1'b0;
        win_c   = '0;
        tie_c   = 1'b0;
        to_c    = 1'b0;
        cyc_nxt = cyc + 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            nxt[i] = (bus.count_en[i] && (cnt[i] != SAT)) ? cnt[i] + 1'b1 : cnt[i];
            hit[i] = (nxt[i] == GOAL_V);
        end
        best = nxt[0];
        if (!mode_r) begin
            if (|hit) begin
                finish = 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (hit[i]) begin
                        if (!found) begin
                            win_c = WIN_W'(i);
                            found = 1'b1;
                        end else begin
                            tie_c = 1'b1;
                        end
                    end
                end
            end else if (cyc_nxt == CYC_W'(MAX_CYCLES)) begin
                finish = 1'b1;
                to_c   = 1'b1;
            end
        end else begin
            finish = (cyc_nxt == CYC_W'(WINDOW));
            for (int i = 1; i < NUM_CH; i++) begin
                if (nxt[i] > best) begin
                    best  = nxt[i];
                    win_c = WIN_W'(i);
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if ((WIN_W'(i) != win_c) && (nxt[i] == best))
                    tie_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            mode_r    <= 1'b0;
            cyc       <= '0;
            winner_r  <= '0;
            tie_r     <= 1'b0;
            timeout_r <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else if ((state != S_IDLE) && bus.abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= S_CLEAR;
                        mode_r <= bus.mode;
                    end
                end
                S_CLEAR: begin
                    cyc       <= '0;
                    winner_r  <= '0;
                    tie_r     <= 1'b0;
                    timeout_r <= 1'b0;
                    for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
                    state     <= S_COUNT;
                end
                S_COUNT: begin
                    cyc <= cyc_nxt;
                    for (int i = 0; i < NUM_CH; i++) cnt[i] <= nxt[i];
                    if (finish) begin
                        state     <= S_DONE;
                        winner_r  <= win_c;
                        tie_r     <= tie_c;
                        timeout_r <= to_c;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // An abort seen during DONE suppresses the completion pulse in that same cycle.
    assign bus.busy    = (state != S_IDLE);
    assign bus.done    = (state == S_DONE) && !bus.abort;
    assign bus.winner  = winner_r;
    assign bus.tie     = tie_r;
    assign bus.timeout = timeout_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_counts
        assign bus.counts[g*CNT_W +: CNT_W] = cnt[g];
    end
endmodule

// File: tb/tb_ro_race_counter.sv
// Directed self-checking bench for ro_race_counter (NUM_CH=4, GOAL=10, WINDOW=20, MAX_CYCLES=50).
// A second instance with CNT_W=4 covers saturation.
module tb_ro_race_counter;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ro_race_counter_if #(.NUM_CH(4), .CNT_W(8), .WIN_W(2)) bus ();
    ro_race_counter_if #(.NUM_CH(4), .CNT_W(4), .WIN_W(2)) bus_s ();

    ro_race_counter #(.NUM_CH(4), .CNT_W(8), .GOAL(10), .WINDOW(20), .MAX_CYCLES(50), .WIN_W(2))
        dut (.clk(clk), .reset(reset), .bus(bus));

    ro_race_counter #(.NUM_CH(4), .CNT_W(4), .GOAL(10), .WINDOW(20), .MAX_CYCLES(50), .WIN_W(2))
        dut_sat (.clk(clk), .reset(reset), .bus(bus_s));

    // Called at a falling edge; start is sampled on the following rising edge (E0).
    task automatic pulse_start(input logic m);
        bus.mode  = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts rising edges after E0 until done is seen; -1 if it never arrives.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", bus.done); end
        checks++; if (bus.counts !== 32'h0) begin errors++; $display("[TB] FAIL reset_counts: got %0h expected 0", bus.counts); end
        checks++; if ({bus.winner, bus.tie, bus.timeout} !== 4'b0) begin errors++; $display("[TB] FAIL reset_result: got %0h expected 0", {bus.winner, bus.tie, bus.timeout}); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_race_single;
        int lat;
        bus.count_en = 4'b0100;
        pulse_start(1'b0);
        wait_done(lat);
        checks++; if (lat !== 11) begin errors++; $display("[TB] FAIL race_latency: got %0d expected 11", lat); end
        checks++; if (bus.winner !== 2'd2) begin errors++; $display("[TB] FAIL race_winner: got %0d expected 2", bus.winner); end
        checks++; if ({bus.tie, bus.timeout} !== 2'b00) begin errors++; $display("[TB] FAIL race_flags: got %0b expected 00", {bus.tie, bus.timeout}); end
        checks++; if (bus.counts !== 32'h000A0000) begin errors++; $display("[TB] FAIL race_counts: got %0h expected a0000", bus.counts); end
        @(negedge clk);
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("[TB] FAIL race_after: got busy/done %0b expected 00", {bus.busy, bus.done}); end
        checks++; if (bus.winner !== 2'd2) begin errors++; $display("[TB] FAIL race_winner_hold: got %0d expected 2", bus.winner); end
        bus.count_en = 4'b0000;
    endtask

    task automatic test_race_tie;
        int lat;
        bus.count_en = 4'b1010;
        pulse_start(1'b0);
        wait_done(lat);
        checks++; if (lat !== 11) begin errors++; $display("[TB] FAIL tie_latency: got %0d expected 11", lat); end
        checks++; if (bus.winner !== 2'd1) begin errors++; $display("[TB] FAIL tie_winner: got %0d expected 1", bus.winner); end
        checks++; if (bus.tie !== 1'b1) begin errors++; $display("[TB] FAIL tie_flag: got %0b expected 1", bus.tie); end
        checks++; if (bus.counts !== 32'h0A000A00) begin errors++; $display("[TB] FAIL tie_counts: got %0h expected a000a00", bus.counts); end
        bus.count_en = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_race_timeout;
        int lat;
        bus.count_en = 4'b0000;
        pulse_start(1'b0);
        wait_done(lat);
        checks++; if (lat !== 51) begin errors++; $display("[TB] FAIL timeout_latency: got %0d expected 51", lat); end
        checks++; if (bus.timeout !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flag: got %0b expected 1", bus.timeout); end
        checks++; if ({bus.winner, bus.tie} !== 3'b000) begin errors++; $display("[TB] FAIL timeout_result: got %0h expected 0", {bus.winner, bus.tie}); end
        checks++; if (bus.counts !== 32'h0) begin errors++; $display("[TB] FAIL timeout_counts: got %0h expected 0", bus.counts); end
        @(negedge clk);
        checks++; if (bus.timeout !== 1'b1) begin errors++; $display("[TB] FAIL timeout_hold: got %0b expected 1", bus.timeout); end
    endtask

    task automatic test_window;
        int lat = -1;
        for (int k = 1; k <= 60; k++) begin
            bus.count_en = {(k % 2 == 0), 2'b00, 1'b1};
            if (k == 1) pulse_start(1'b1);
            else @(negedge clk);
            if (bus.done) begin
                lat = k - 1;
                break;
            end
        end
        bus.count_en = 4'b0000;
        checks++; if (lat !== 21) begin errors++; $display("[TB] FAIL window_latency: got %0d expected 21", lat); end
        checks++; if (bus.counts !== 32'h0A000014) begin errors++; $display("[TB] FAIL window_counts: got %0h expected a000014", bus.counts); end
        checks++; if ({bus.winner, bus.tie, bus.timeout} !== 4'b0000) begin errors++; $display("[TB] FAIL window_result: got %0h expected 0", {bus.winner, bus.tie, bus.timeout}); end
        @(negedge clk);
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("[TB] FAIL window_after: got busy/done %0b expected 00", {bus.busy, bus.done}); end
    endtask

    task automatic test_window_tie;
        int lat;
        bus.count_en = 4'b0110;
        pulse_start(1'b1);
        wait_done(lat);
        checks++; if (lat !== 21) begin errors++; $display("[TB] FAIL wtie_latency: got %0d expected 21", lat); end
        checks++; if ({bus.winner, bus.tie} !== 3'b011) begin errors++; $display("[TB] FAIL wtie_result: got %0h expected 3", {bus.winner, bus.tie}); end
        checks++; if (bus.counts !== 32'h00141400) begin errors++; $display("[TB] FAIL wtie_counts: got %0h expected 141400", bus.counts); end
        bus.count_en = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_window_sat;
        int lat = -1;
        bus_s.count_en = 4'b0010;
        bus_s.mode     = 1'b1;
        bus_s.start    = 1'b1;
        @(negedge clk);
        bus_s.start    = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus_s.done) begin
                lat = k;
                break;
            end
        end
        checks++; if (lat !== 21) begin errors++; $display("[TB] FAIL sat_latency: got %0d expected 21", lat); end
        checks++; if (bus_s.counts !== 16'h00F0) begin errors++; $display("[TB] FAIL sat_counts: got %0h expected f0", bus_s.counts); end
        checks++; if ({bus_s.winner, bus_s.tie} !== 3'b010) begin errors++; $display("[TB] FAIL sat_result: got %0h expected 2", {bus_s.winner, bus_s.tie}); end
        bus_s.count_en = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_abort;
        logic seen_done = 1'b0;
        bus.count_en = 4'b0001;
        pulse_start(1'b0);
        repeat (5) @(negedge clk);
        checks++; if (bus.counts !== 32'h4) begin errors++; $display("[TB] FAIL abort_live_counts: got %0h expected 4", bus.counts); end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %0b expected 0", bus.busy); end
        for (int k = 0; k < 15; k++) begin
            if (bus.done) seen_done = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_done: got %0b expected 0", seen_done); end
        checks++; if (bus.counts !== 32'h4) begin errors++; $display("[TB] FAIL abort_frozen: got %0h expected 4", bus.counts); end
        bus.count_en = 4'b0000;
    endtask

    task automatic test_back_to_back;
        int lat = -1;
        bus.count_en = 4'b0100;
        bus.mode     = 1'b0;
        bus.start    = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        bus.start = 1'b0;
        checks++; if (lat !== 11) begin errors++; $display("[TB] FAIL held_start_latency: got %0d expected 11", lat); end
        checks++; if (bus.counts !== 32'h000A0000) begin errors++; $display("[TB] FAIL held_start_counts: got %0h expected a0000", bus.counts); end
        bus.count_en = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bus.count_en = 4'b0001;
        pulse_start(1'b1);
        repeat (5) @(negedge clk);
        checks++; if (bus.counts !== 32'h4) begin errors++; $display("[TB] FAIL mid_live_counts: got %0h expected 4", bus.counts); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("[TB] FAIL mid_reset_busy: got %0b expected 00", {bus.busy, bus.done}); end
        checks++; if (bus.counts !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_counts: got %0h expected 0", bus.counts); end
        @(negedge clk);
        reset = 1'b0;
        bus.count_en = 4'b0000;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_idle: got %0b expected 0", bus.busy); end
    endtask

    initial begin
        bus.start = 1'b0;  bus.mode = 1'b0;  bus.abort = 1'b0;  bus.count_en = '0;
        bus_s.start = 1'b0; bus_s.mode = 1'b0; bus_s.abort = 1'b0; bus_s.count_en = '0;
        test_reset;
        test_race_single;
        test_race_tie;
        test_race_timeout;
        test_window;
        test_window_tie;
        test_window_sat;
        test_abort;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
